mcp3_decoder_pipe: RTL
======================

Name: mcp3_decoder_pipe

Overview:
Parametrised, pipelined binary-to-vector decoder for the AFP datapath. It generalises the fixed 5-to-32 decoder to any input width. It also adds thermometer and sticky-accumulate decode modes and a valid/ready handshake, so it can sit between tag/credit logic and the bitmap trackers without extra glue registers. It uses a two-level decode (low SUB_WIDTH bits, then group select) split across two pipeline stages for timing.

Parameters:
DIN_WIDTH, 5, width of binary input; legal range 1..8.
SUB_WIDTH, 3, width decoded in stage 1; legal range 1..DIN_WIDTH; there are 2**(DIN_WIDTH-SUB_WIDTH) groups.
DOUT_WIDTH, 2**DIN_WIDTH, derived localparam, not overridable.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  din/in_mode valid.
in_ready  output  1  block can accept this cycle.
din  input  DIN_WIDTH  binary index.
in_mode  input  2  00 one-hot, 01 therm-low, 10 therm-high, 11 accumulate.
clear_acc  input  1  clear accumulate mask (independent of in_valid).
out_valid  output  1  dout valid.
out_ready  input  1  consumer accepts dout.
dout  output  DOUT_WIDTH  decoded vector.
acc_mask  output  DOUT_WIDTH  current accumulate register.
acc_full  output  1  acc_mask all ones.

Behaviour:
- Clock and reset: one clock domain (clock); reset is synchronous and active-high. On a reset cycle:
  - s1_valid, s2_valid, out_valid, dout, acc_mask and acc_full all go to 0.
  - in_ready is held 0 while reset is high and is 1 in the first cycle after reset.
- Stage 1 registers (load on in_valid && in_ready):
  - low = 2**SUB_WIDTH one-hot decode of din[SUB_WIDTH-1:0];
  - grp = din[DIN_WIDTH-1:SUB_WIDTH] (zero width: single group, grp treated as 0);
  - low thermometer = bits 0..din[SUB_WIDTH-1:0] set;
  - mode.
- Stage 2 registers (load when s1_valid && s2_adv): final vector placed at group offset grp*2**SUB_WIDTH.
  - 00: one-hot, bit din only.
  - 01: bits 0..din set (din=0 gives 0x1; max din gives all ones).
  - 10: bits din..DOUT_WIDTH-1 set (din=0 gives all ones).
  - 11: dout = next acc_mask (see accumulate).
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !reset && (!s1_valid || s2_adv).
  - s1_valid set on accept, cleared when it moves to stage 2 with no new accept.
  - Latency din->dout is 2 cycles with no stall. Throughput is 1 per cycle.
  - dout and out_valid are stable while out_valid && !out_ready.
  - No combinational path from in_valid/din to outputs; out_ready->in_ready is combinational.
- Accumulate register (acc):
  - Mode-11 item entering stage 2: acc <= (clear_acc ? 0 : acc) | onehot(din); dout gets that same new value.
  - clear_acc with no mode-11 load: acc <= 0; dout is unchanged.
  - Modes 00/01/10 never modify acc.
  - Setting an already-set bit is legal, with no error.
  - acc_mask is the registered acc. acc_full = &acc, registered together with acc.
- Simultaneous events:
  - Accept and stage-2 drain in the same cycle are both performed.
  - clear_acc during a stall with a mode-11 item held in stage 1: clear takes effect now; the held item is applied later against the cleared mask.
- Reset mid-operation: in-flight items are discarded, with no output beat.

Test Plan:
- Default params, mode 00, din=31, out_ready=1 -> two cycles later out_valid=1, dout=0x80000000; din=0 -> 0x00000001.
- Mode 01 din=5 -> dout=0x0000003F; mode 10 din=5 -> 0xFFFFFFE0; mode 01 din=31 -> 0xFFFFFFFF; mode 10 din=0 -> 0xFFFFFFFF.
- Mode 11, back-to-back din=0,3,31 -> dout 0x00000001, 0x00000009, 0x80000009; acc_mask=0x80000009; acc_full=0. Drive all 32 indices -> acc_full=1. clear_acc together with a din=4 load -> dout=acc_mask=0x00000010.
- Stall: issue 4 items one per cycle with out_ready=0 -> in_ready drops after 2 accepted; dout holds the first value; raise out_ready -> all 4 delivered in order with no loss or duplication.
- Parameter sweep DIN_WIDTH/SUB_WIDTH = 1/1, 4/4, 8/3, 8/8 -> exhaustive din in all modes matches a reference model.
- Assert reset with both stages full and acc=0xFFFF0000 -> next cycle out_valid=0, acc_mask=0, acc_full=0, in_ready=1 after reset drops; no stale beat.

Source files
------------

// File: rtl/mcp3_decoder_pipe.sv
`default_nettype none
// ==== mcp3_decoder_pipe : two-stage binary-to-vector decoder (one-hot / thermometer / sticky
// ==== accumulate) with valid/ready handshake  |  rev 1.0
module mcp3_decoder_pipe #(
   parameter int DIN_WIDTH = 5,
   parameter int SUB_WIDTH = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DIN_WIDTH-1:0]         din,
   input  logic [1:0]                   in_mode,
   input  logic                         clear_acc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [(1<<DIN_WIDTH)-1:0]    dout,
   output logic [(1<<DIN_WIDTH)-1:0]    acc_mask,
   output logic                         acc_full
);

   localparam int DOUT_WIDTH = 1 << DIN_WIDTH;
   localparam int LOW_W      = 1 << SUB_WIDTH;
   localparam int GRP_W      = DIN_WIDTH - SUB_WIDTH;
   localparam int GRP_RW     = (GRP_W > 0) ? GRP_W : 1;
   localparam int NUM_GRP    = 1 << GRP_W;

   localparam logic [1:0] MODE_ONEHOT   = 2'b00;
   localparam logic [1:0] MODE_THERM_LO = 2'b01;
   localparam logic [1:0] MODE_THERM_HI = 2'b10;
   localparam logic [1:0] MODE_ACC      = 2'b11;

   logic [SUB_WIDTH-1:0]  din_low;
   logic [GRP_RW-1:0]     din_grp;
   logic [LOW_W-1:0]      low_dec;
   logic [LOW_W-1:0]      low_therm;

   logic                  s1_valid;
   logic [LOW_W-1:0]      s1_low;
   logic [LOW_W-1:0]      s1_therm;
   logic [GRP_RW-1:0]     s1_grp;
   logic [1:0]            s1_mode;
   logic                  s2_valid;

   logic                  s2_adv;
   logic                  accept;
   logic                  s2_load;
   logic [DOUT_WIDTH-1:0] dec_vec;
   logic [DOUT_WIDTH-1:0] onehot_vec;
   logic [DOUT_WIDTH-1:0] acc_next;

   assign din_low = din[SUB_WIDTH-1:0];

   // With no group bits there is a single group, index 0.
   generate
      if (GRP_W > 0) begin : g_grp_bits
         assign din_grp = din[DIN_WIDTH-1:SUB_WIDTH];
      end else begin : g_grp_none
         assign din_grp = 1'b0;
      end
   endgenerate

   always_comb begin
      low_dec   = '0;
      low_therm = '0;
      for (int i = 0; i < LOW_W; i++) begin
         low_dec[i]   = (din_low == SUB_WIDTH'(i));
         low_therm[i] = (SUB_WIDTH'(i) <= din_low);
      end
   end

   assign s2_adv   = !s2_valid || out_ready;
   assign in_ready = !reset && (!s1_valid || s2_adv);
   assign accept   = in_valid && in_ready;
   assign s2_load  = s1_valid && s2_adv;

   // Groups below the selected one are fully inside a low thermometer, groups above it fully
   // inside a high thermometer; only the selected group takes the stage-1 sub-decode.
   always_comb begin
      dec_vec    = '0;
      onehot_vec = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         onehot_vec[g*LOW_W +: LOW_W] = (s1_grp == GRP_RW'(g)) ? s1_low : '0;
         case (s1_mode)
            MODE_ONEHOT: begin
               dec_vec[g*LOW_W +: LOW_W] = (s1_grp == GRP_RW'(g)) ? s1_low : '0;
            end
            MODE_THERM_LO: begin
               if (s1_grp == GRP_RW'(g))
                  dec_vec[g*LOW_W +: LOW_W] = s1_therm;
               else if (GRP_RW'(g) < s1_grp)
                  dec_vec[g*LOW_W +: LOW_W] = {LOW_W{1'b1}};
               else
                  dec_vec[g*LOW_W +: LOW_W] = '0;
            end
            MODE_THERM_HI: begin
               if (s1_grp == GRP_RW'(g))
                  dec_vec[g*LOW_W +: LOW_W] = ~s1_therm | s1_low;
               else if (GRP_RW'(g) < s1_grp)
                  dec_vec[g*LOW_W +: LOW_W] = '0;
               else
                  dec_vec[g*LOW_W +: LOW_W] = {LOW_W{1'b1}};
            end
            default: begin
               dec_vec[g*LOW_W +: LOW_W] = '0;
            end
         endcase
      end
   end

   // A clear arriving with the mode-11 load is applied first, so the new bit survives.
   assign acc_next = (clear_acc ? '0 : acc_mask) | onehot_vec;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_low   <= '0;
         s1_therm <= '0;
         s1_grp   <= '0;
         s1_mode  <= MODE_ONEHOT;
         s2_valid <= 1'b0;
         dout     <= '0;
         acc_mask <= '0;
         acc_full <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_low   <= low_dec;
            s1_therm <= low_therm;
            s1_grp   <= din_grp;
            s1_mode  <= in_mode;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_adv)
            s2_valid <= s1_valid;

         if (s2_load)
            dout <= (s1_mode == MODE_ACC) ? acc_next : dec_vec;

         if (s2_load && (s1_mode == MODE_ACC)) begin
            acc_mask <= acc_next;
            acc_full <= &acc_next;
         end else if (clear_acc) begin
            acc_mask <= '0;
            acc_full <= 1'b0;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule
`default_nettype wire
